// File: rtl/mig_tb_ram.sv
// Word-addressed simulation RAM beside the MigU core: streamed preload from the C bench,
// then single-cycle fetch and data ports once the load has completed.
module mig_tb_ram #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORD_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic [ADDR_WIDTH-3:0]   ld_base,
  input  logic                    ld_valid,
  input  logic [WORD_BITS-1:0]    ld_data,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    load_done,
  output logic                    cpu_hold,
  input  logic                    if_req_valid,
  input  logic [ADDR_WIDTH-3:0]   if_req_addr,
  output logic                    if_req_ready,
  output logic                    if_rsp_valid,
  output logic [WORD_BITS-1:0]    if_rsp_insn,
  input  logic                    dm_req_valid,
  input  logic                    dm_req_we,
  input  logic [ADDR_WIDTH-3:0]   dm_req_addr,
  input  logic [WORD_BITS-1:0]    dm_req_wdata,
  input  logic [WORD_BITS/8-1:0]  dm_req_be,
  output logic                    dm_req_ready,
  output logic                    dm_rsp_valid,
  output logic [WORD_BITS-1:0]    dm_rsp_rdata
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned BW    = WORD_BITS / 8;
  localparam int unsigned DEPTH = 2 ** IW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IW-1:0]          r_ptr;
  logic                   r_ld_ready;
  logic                   r_load_done;
  logic                   r_cpu_hold;
  logic                   r_if_req_ready;
  logic                   r_dm_req_ready;
  logic                   r_if_rsp_valid;
  logic [WORD_BITS-1:0]   r_if_rsp_insn;
  logic                   r_dm_rsp_valid;
  logic [WORD_BITS-1:0]   r_dm_rsp_rdata;
  logic [WORD_BITS-1:0]   r_mem [DEPTH];

  logic                   w_ld_we;
  logic                   w_ld_fin;
  logic                   w_if_acc;
  logic                   w_dm_acc;
  logic                   w_dm_wr;
  logic [WORD_BITS-1:0]   w_be_mask;

  assign w_ld_we  = (r_state == S_LOAD) && ld_valid;
  assign w_ld_fin = w_ld_we && ld_last;
  assign w_if_acc = if_req_valid && r_if_req_ready;
  assign w_dm_acc = dm_req_valid && r_dm_req_ready;
  assign w_dm_wr  = w_dm_acc && dm_req_we;

  // Expand byte enables into a bit mask for the data-port merge.
  for (genvar g = 0; g < BW; g++) begin : g_mask
    assign w_be_mask[8*g +: 8] = {8{dm_req_be[g]}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ld_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_ld_fin) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_ready     <= 1'b0;
      r_load_done    <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_if_req_ready <= 1'b0;
      r_dm_req_ready <= 1'b0;
      r_ptr          <= '0;
    end else begin
      r_ld_ready     <= (w_state_nxt == S_LOAD);
      r_load_done    <= w_ld_fin;
      r_cpu_hold     <= (w_state_nxt != S_RUN);
      r_if_req_ready <= (w_state_nxt == S_RUN);
      r_dm_req_ready <= (w_state_nxt == S_RUN);
      if ((r_state == S_IDLE) && ld_start) r_ptr <= ld_base;
      else if (w_ld_we)                    r_ptr <= r_ptr + IW'(1);
    end
  end

  // Array is never reset; load and data writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (w_ld_we) r_mem[r_ptr] <= ld_data;
    if (w_dm_wr) r_mem[dm_req_addr] <= (r_mem[dm_req_addr] & ~w_be_mask) | (dm_req_wdata & w_be_mask);
  end

  // Responses read the pre-edge array contents, giving read-before-write on conflicts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_insn  <= '0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_rdata <= '0;
    end else begin
      r_if_rsp_valid <= w_if_acc;
      r_dm_rsp_valid <= w_dm_acc;
      if (w_if_acc) r_if_rsp_insn  <= r_mem[if_req_addr];
      if (w_dm_acc) r_dm_rsp_rdata <= dm_req_we ? '0 : r_mem[dm_req_addr];
    end
  end

  assign ld_ready     = r_ld_ready;
  assign load_done    = r_load_done;
  assign cpu_hold     = r_cpu_hold;
  assign if_req_ready = r_if_req_ready;
  assign dm_req_ready = r_dm_req_ready;
  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_insn  = r_if_rsp_insn;
  assign dm_rsp_valid = r_dm_rsp_valid;
  assign dm_rsp_rdata = r_dm_rsp_rdata;

endmodule

// File: tb/tb_mig_tb_ram.sv
// Bench for mig_tb_ram: directed load/run scenarios plus random traffic against
// an associative-array memory model.
module tb_mig_tb_ram;

  localparam int unsigned DEPTH = 1 << 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last;
  logic [13:0] ld_base;
  logic [31:0] ld_data;
  logic        ld_ready, load_done, cpu_hold;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [13:0] if_req_addr;
  logic [31:0] if_rsp_insn;
  logic        dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
  logic [13:0] dm_req_addr;
  logic [31:0] dm_req_wdata, dm_rsp_rdata;
  logic [3:0]  dm_req_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [int unsigned];
  int unsigned lptr;

  mig_tb_ram dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .load_done(load_done), .cpu_hold(cpu_hold),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_insn(if_rsp_insn),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input int unsigned a);
    if (mdl.exists(a)) return mdl[a];
    return 32'hxxxx_xxxx;
  endfunction

  // Byte-wise merge of a partial write into the old word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic start_load(input logic [13:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
    lptr     = base;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    mdl[lptr] = d;
    lptr      = (lptr + 1) % DEPTH;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
  endtask

  // One RUN cycle: optional fetch and/or data request, checked one cycle later.
  task automatic req(input logic iv, input logic [13:0] ia, input logic dv, input logic we,
                     input logic [13:0] da, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] ei, ed;
    ei = iv ? mdl_rd(ia) : 32'h0;
    ed = (dv && !we) ? mdl_rd(da) : 32'h0;
    if_req_valid = iv; if_req_addr = ia;
    dm_req_valid = dv; dm_req_we = we; dm_req_addr = da; dm_req_wdata = wd; dm_req_be = be;
    tick();
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(iv));
    if (iv) check("if_rsp_insn", if_rsp_insn, ei);
    check("dm_rsp_valid", 32'(dm_rsp_valid), 32'(dv));
    if (dv) check("dm_rsp_rdata", dm_rsp_rdata, ed);
    if (dv && we) mdl[da] = merge(mdl_rd(da), wd, be);
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    if_req_valid = 0; if_req_addr = 0;
    dm_req_valid = 0; dm_req_we = 0; dm_req_addr = 0; dm_req_wdata = 0; dm_req_be = 0;
    tick(); tick();
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_if_ready", 32'(if_req_ready), 32'd0);
    check("rst_dm_ready", 32'(dm_req_ready), 32'd0);
    check("rst_if_valid", 32'(if_rsp_valid), 32'd0);
    check("rst_dm_valid", 32'(dm_rsp_valid), 32'd0);
    check("rst_if_insn", if_rsp_insn, 32'd0);
    check("rst_dm_rdata", dm_rsp_rdata, 32'd0);
    rst = 1'b1;

    // Requests in IDLE are never accepted
    if_req_valid = 1; if_req_addr = 14'h10; dm_req_valid = 1; dm_req_addr = 14'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_if_ready", 32'(if_req_ready), 32'd0);
      check("idle_dm_ready", 32'(dm_req_ready), 32'd0);
      check("idle_if_valid", 32'(if_rsp_valid), 32'd0);
      check("idle_dm_valid", 32'(dm_rsp_valid), 32'd0);
    end
    if_req_valid = 0; dm_req_valid = 0;

    // ld_start with ld_valid: the word is dropped
    ld_valid = 1; ld_data = 32'hBAD0BAD0;
    start_load(14'h0010);
    ld_valid = 0;
    check("load_ld_ready", 32'(ld_ready), 32'd1);
    check("load_cpu_hold", 32'(cpu_hold), 32'd1);
    send(32'h00000013, 1'b0);
    check("load_done_w0", 32'(load_done), 32'd0);
    ld_last = 1; tick(); ld_last = 0;
    check("last_no_valid_done", 32'(load_done), 32'd0);
    check("last_no_valid_ready", 32'(ld_ready), 32'd1);
    send(32'h00100093, 1'b0);
    check("load_done_w1", 32'(load_done), 32'd0);
    send(32'h00208113, 1'b1);
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("run_cpu_hold", 32'(cpu_hold), 32'd0);
    check("run_if_ready", 32'(if_req_ready), 32'd1);
    check("run_ld_ready", 32'(ld_ready), 32'd0);
    req(1, 14'h11, 0, 0, 0, 0, 0);
    check("load_done_once", 32'(load_done), 32'd0);
    check("fetch_0x11", if_rsp_insn, 32'h00100093);
    req(1, 14'h10, 0, 0, 0, 0, 0);
    check("fetch_0x10", if_rsp_insn, 32'h00000013);
    req(0, 0, 0, 0, 0, 0, 0);

    ld_start = 1; tick(); tick(); ld_start = 0;
    check("run_start_ld_ready", 32'(ld_ready), 32'd0);
    check("run_start_hold", 32'(cpu_hold), 32'd0);

    // Byte-enable merge and be=0 write
    req(0, 0, 1, 1, 14'h40, 32'h11223344, 4'hF);
    req(0, 0, 1, 1, 14'h40, 32'hDEADBEEF, 4'b0101);
    req(0, 0, 1, 0, 14'h40, 0, 0);
    check("be_merge", dm_rsp_rdata, 32'h11AD33EF);
    req(0, 0, 1, 1, 14'h40, 32'hFFFFFFFF, 4'h0);
    req(0, 0, 1, 0, 14'h40, 0, 0);
    check("be_zero", dm_rsp_rdata, 32'h11AD33EF);

    // Fetch/write conflict: read-before-write
    req(0, 0, 1, 1, 14'h20, 32'h00000013, 4'hF);
    req(1, 14'h20, 1, 1, 14'h20, 32'hFFFFFFFF, 4'hF);
    check("conflict_old", if_rsp_insn, 32'h00000013);
    req(1, 14'h20, 0, 0, 0, 0, 0);
    check("conflict_new", if_rsp_insn, 32'hFFFFFFFF);

    // Random traffic over a small window
    for (int a = 8'h20; a < 8'h30; a++) req(0, 0, 1, 1, 14'(a), $urandom, 4'hF);
    for (int i = 0; i < 300; i++) begin
      req(1'($urandom_range(0, 1)), 14'(8'h20 + $urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'(8'h20 + $urandom_range(0, 15)),
          $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset clears pending responses
    if_req_valid = 1; if_req_addr = 14'h20; dm_req_valid = 1; dm_req_we = 0; dm_req_addr = 14'h21;
    tick();
    if_req_valid = 0; dm_req_valid = 0;
    rst = 1'b0; #1;
    check("rst_clr_if_valid", 32'(if_rsp_valid), 32'd0);
    check("rst_clr_dm_valid", 32'(dm_rsp_valid), 32'd0);
    check("rst_clr_hold", 32'(cpu_hold), 32'd1);
    tick(); rst = 1'b1;

    // Wrapping load from the last word index
    start_load(14'h3FFF);
    send(32'hAAAA5555, 1'b0);
    send(32'h12345678, 1'b1);
    check("wrap_done", 32'(load_done), 32'd1);
    req(1, 14'h3FFF, 1, 0, 14'h0000, 0, 0);
    check("wrap_top", if_rsp_insn, 32'hAAAA5555);
    check("wrap_zero", dm_rsp_rdata, 32'h12345678);

    // Reset mid-load keeps already-written words
    rst = 1'b0; tick(); rst = 1'b1;
    start_load(14'h0100);
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    rst = 1'b0; #1;
    check("midload_hold", 32'(cpu_hold), 32'd1);
    check("midload_ld_ready", 32'(ld_ready), 32'd0);
    check("midload_done", 32'(load_done), 32'd0);
    tick(); rst = 1'b1;
    start_load(14'h0200);
    send(32'h0badf00d, 1'b1);
    check("reload_done", 32'(load_done), 32'd1);
    req(1, 14'h0100, 1, 0, 14'h0101, 0, 0);
    req(1, 14'h0200, 0, 0, 0, 0, 0);
    req(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
